// File: rtl/multiway_light_controller.sv
// N-way traffic-light controller: round-robin green service with demand skipping,
// tick-timed green/yellow/all-red phases and registered lamp outputs.
module multiway_light_controller #(
   parameter int N_WAYS    = 4,
   parameter int CNT_W     = 8,
   parameter int MIN_GREEN = 3,
   parameter int MAX_GREEN = 6,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   localparam int AW       = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [N_WAYS-1:0] sense,
   output logic [N_WAYS-1:0] green,
   output logic [N_WAYS-1:0] yellow,
   output logic [N_WAYS-1:0] red,
   output logic [AW-1:0]     active_way,
   output logic [1:0]        phase
);

   localparam logic [1:0] PH_GREEN  = 2'd0;
   localparam logic [1:0] PH_YELLOW = 2'd1;
   localparam logic [1:0] PH_ALLRED = 2'd2;

   localparam logic [CNT_W:0]   MIN_C    = (CNT_W+1)'(MIN_GREEN);
   localparam logic [CNT_W:0]   MAX_C    = (CNT_W+1)'(MAX_GREEN);
   localparam logic [CNT_W:0]   YEL_C    = (CNT_W+1)'(YELLOW_T);
   localparam logic [CNT_W:0]   AR_C     = (CNT_W+1)'(ALLRED_T);
   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [N_WAYS-1:0] ONE_HOT0 = {{(N_WAYS-1){1'b0}}, 1'b1};

   logic [AW-1:0]     next_way;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W:0]    cnt_inc;
   logic [N_WAYS-1:0] active_mask;
   logic              other_demand;
   logic [AW-1:0]     found_way;
   logic [AW-1:0]     cand;

   logic [1:0]        phase_n;
   logic [AW-1:0]     way_n;
   logic [AW-1:0]     next_way_n;
   logic [CNT_W-1:0]  cnt_n;
   logic [N_WAYS-1:0] green_n;
   logic [N_WAYS-1:0] yellow_n;

   assign cnt_inc      = {1'b0, cnt} + 1'b1;
   assign active_mask  = ONE_HOT0 << active_way;
   assign other_demand = |(sense & ~active_mask);

   // Scan downward so the nearest demanding index after active_way is written last.
   always_comb begin
      found_way = active_way;
      cand      = '0;
      for (int i = N_WAYS - 1; i >= 1; i--) begin
         cand = AW'((int'(active_way) + i) % N_WAYS);
         if (sense[cand]) found_way = cand;
      end
   end

   always_comb begin
      phase_n    = phase;
      way_n      = active_way;
      next_way_n = next_way;
      cnt_n      = cnt;
      if (tick) begin
         case (phase)
            PH_GREEN: begin
               if (cnt_inc >= MIN_C && other_demand &&
                   (!sense[active_way] || cnt_inc >= MAX_C)) begin
                  phase_n    = PH_YELLOW;
                  next_way_n = found_way;
                  cnt_n      = '0;
               end else if (cnt != CNT_SAT) begin
                  cnt_n = cnt_inc[CNT_W-1:0];
               end
            end
            PH_YELLOW: begin
               if (cnt_inc == YEL_C) begin
                  cnt_n = '0;
                  if (ALLRED_T == 0) begin
                     phase_n = PH_GREEN;
                     way_n   = next_way;
                  end else begin
                     phase_n = PH_ALLRED;
                  end
               end else begin
                  cnt_n = cnt_inc[CNT_W-1:0];
               end
            end
            PH_ALLRED: begin
               if (cnt_inc == AR_C) begin
                  phase_n = PH_GREEN;
                  way_n   = next_way;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc[CNT_W-1:0];
               end
            end
            default: begin
               phase_n = PH_GREEN;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Lamps are derived from the next state so they change on the same edge as phase.
   always_comb begin
      green_n  = '0;
      yellow_n = '0;
      if (phase_n == PH_GREEN)  green_n  = ONE_HOT0 << way_n;
      if (phase_n == PH_YELLOW) yellow_n = ONE_HOT0 << way_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= PH_GREEN;
         active_way <= '0;
         next_way   <= '0;
         cnt        <= '0;
         green      <= ONE_HOT0;
         yellow     <= '0;
         red        <= ~ONE_HOT0;
      end else begin
         phase      <= phase_n;
         active_way <= way_n;
         next_way   <= next_way_n;
         cnt        <= cnt_n;
         green      <= green_n;
         yellow     <= yellow_n;
         red        <= ~(green_n | yellow_n);
      end
   end

endmodule
